// File: rtl/alu_pkg.sv
// Shared opcode and sequencer-state types for the logic half of the ALU,
// plus the opcode normalisation helpers used by the sequencer front-end.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_SRL = 3'b011,
    OP_SLL = 3'b100,
    OP_ROL = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_e;

  // Reserved encodings 110/111 execute as AND.
  function automatic op_e norm_op(input logic [2:0] raw);
    case (raw)
      3'b110, 3'b111: return OP_AND;
      default:        return op_e'(raw);
    endcase
  endfunction

  function automatic logic is_shift(input op_e op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-bit shift/rotate step (SRL, SLL, ROL) applied to the
// sequencer's working register once per SHIFT cycle.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_data,
  input  op_e          i_op,
  output logic [N-1:0] o_data
);

  always_comb begin
    // NOTE: default assignment first so every path drives o_data (no latch).
    o_data = i_data;
    case (i_op)
      OP_SRL:  o_data = {1'b0, i_data[N-1:1]};
      OP_SLL:  o_data = {i_data[N-2:0], 1'b0};
      OP_ROL:  o_data = {i_data[N-2:0], i_data[N-1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle logic/shift execution front-end with valid/ready on both sides.
// Optional macro ALU_SEQ_BYPASS_EN lets a new command enter during the output handshake.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         flag_z,
  output logic         flag_n,
  output logic         busy
);

  localparam int CW = $clog2(N);

  seq_state_e  r_state;
  seq_state_e  w_state_next;
  op_e         r_op;
  logic [N-1:0]  r_work;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_result;
  logic          r_z;
  logic          r_n;

  op_e           w_op;
  logic [CW-1:0] w_amt;
  logic          w_is_shift;
  logic          w_accept;
  logic [N-1:0]  w_logic;
  logic [N-1:0]  w_step;
  logic [N-1:0]  w_final;
  logic          w_load;

  assign w_op       = norm_op(op);
  assign w_amt      = b[CW-1:0];
  assign w_is_shift = is_shift(w_op);
  assign w_accept   = in_valid & in_ready;

  always_comb begin
    w_logic = a & b;
    case (w_op)
      OP_OR:   w_logic = a | b;
      OP_XOR:  w_logic = a ^ b;
      default: w_logic = a & b;
    endcase
  end

  alu_shift_step #(.N(N)) u_step (
    .i_data (r_work),
    .i_op   (r_op),
    .o_data (w_step)
  );

  // A new command writes the result directly for logic ops and k=0 shifts;
  // otherwise the last SHIFT step (counter at 1) writes it.
  assign w_final = w_accept ? (w_is_shift ? a : w_logic) : w_step;
  assign w_load  = w_accept ? (!w_is_shift || (w_amt == '0))
                            : ((r_state == ST_SHIFT) && (r_cnt == CW'(1)));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept)
          w_state_next = (w_is_shift && (w_amt != '0)) ? ST_SHIFT : ST_DONE;
        else if ((r_state == ST_DONE) && out_ready)
          w_state_next = ST_IDLE;
      end
      ST_SHIFT: if (r_cnt == CW'(1)) w_state_next = ST_DONE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
`ifdef ALU_SEQ_BYPASS_EN
    in_ready = ~rst & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
`else
    in_ready = ~rst & (r_state == ST_IDLE);
`endif
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too so result/flags come up at zero.
    if (rst) begin
      r_op     <= OP_AND;
      r_work   <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= w_op;
        r_work <= a;
        r_cnt  <= w_amt;
      end else if (r_state == ST_SHIFT) begin
        r_work <= w_step;
        r_cnt  <= r_cnt - 1'b1;
      end
      if (w_load) begin
        r_result <= w_final;
        r_z      <= (w_final == '0);
        r_n      <= w_final[N-1];
      end
    end
  end

  assign result = r_result;
  assign flag_z = r_z;
  assign flag_n = r_n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with an expected-result
// scoreboard; inputs driven and outputs sampled on the falling edge.
module tb_alu_op_sequencer;

  localparam int N  = 8;
  localparam int CW = $clog2(N);
`ifdef ALU_SEQ_BYPASS_EN
  localparam int ACC_GAP = 1;
`else
  localparam int ACC_GAP = 2;
`endif

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         flag_z, flag_n, busy;
  logic [N-1:0] a, b, result;
  logic [2:0]   op;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .busy      (busy)
  );

  typedef struct {
    logic [N-1:0] res;
    logic         z;
    logic         n;
    int           lat;
    int           t_acc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: shifts computed by whole-amount operators, not stepwise.
  function automatic exp_t model(input logic [2:0] o, input logic [N-1:0] x,
                                 input logic [N-1:0] y, input int t);
    exp_t e;
    logic [CW-1:0] kk;
    int k;
    kk = y[CW-1:0];
    k  = int'(kk);
    case (o)
      3'b001:  e.res = x | y;
      3'b010:  e.res = x ^ y;
      3'b011:  e.res = x >> k;
      3'b100:  e.res = x << k;
      3'b101:  e.res = (k == 0) ? x : ((x << k) | (x >> (N - k)));
      default: e.res = x & y;
    endcase
    e.z     = (e.res == '0);
    e.n     = e.res[N-1];
    e.lat   = (o == 3'b011 || o == 3'b100 || o == 3'b101) ? 1 + k : 1;
    e.t_acc = t;
    return e;
  endfunction

  task automatic send(input logic [2:0] o, input logic [N-1:0] x,
                      input logic [N-1:0] y, output int t_acc);
    int n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    t_acc = -1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", in_ready, 1'b1);
    t_acc = cyc;
    sb.push_back(model(o, x, y, cyc));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic receive(input string tag, input int hold);
    exp_t e;
    int   n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    e = sb.pop_front();
    check({tag, "_latency"}, cyc - e.t_acc, e.lat);
    check({tag, "_result"}, result, e.res);
    check({tag, "_flag_z"}, flag_z, e.z);
    check({tag, "_flag_n"}, flag_n, e.n);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_result"}, result, e.res);
      check({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
  endtask

  logic [2:0]   tp_op[4] = '{3'b000, 3'b001, 3'b010, 3'b110};
  logic [N-1:0] tp_a[4]  = '{8'hF0, 8'h12, 8'h0F, 8'hC3};
  logic [N-1:0] tp_b[4]  = '{8'h3C, 8'h81, 8'hFF, 8'h96};

  initial begin
    int   t, t_rel, idx, got;
    bit   adv;
    int   acc[$];
    exp_t e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 8'h00);
    check("rst_flag_z", flag_z, 1'b0);
    check("rst_flag_n", flag_n, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1'b1);

    send(3'b000, 8'hF0, 8'h3C, t); receive("and", 0);
    send(3'b010, 8'hAA, 8'hAA, t); receive("xor_hold", 5);
    send(3'b101, 8'h81, 8'h03, t); receive("rol3", 0);
    send(3'b011, 8'h80, 8'h0F, t); receive("srl7", 0);
    send(3'b100, 8'h5A, 8'h08, t); receive("sll0", 0);
    send(3'b100, 8'h5A, 8'h02, t); receive("sll2", 0);
    send(3'b111, 8'hFF, 8'h81, t); receive("rsv7", 0);

    // Reset during a k=5 shift: the command is dropped, a new one enters at once.
    send(3'b011, 8'hC3, 8'h05, t);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    sb.delete();
    #1;
    t_rel = cyc;
    check("mid_rel_in_ready", in_ready, 1'b1);
    check("mid_rel_result", result, 8'h00);
    check("mid_rel_busy", busy, 1'b0);
    send(3'b001, 8'h12, 8'h03, t);
    check("mid_accept_cycle", t, t_rel);
    receive("after_rst", 0);

    // Back-to-back logic commands with the consumer always ready.
    @(negedge clk);
    idx = 0; got = 0; adv = 1'b0;
    op = tp_op[0]; a = tp_a[0]; b = tp_b[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("tp_extra_output", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("tp_result", result, e.res);
          check("tp_flag_z", flag_z, e.z);
          got++;
        end
      end
      if (adv) begin
        if (idx < 4) begin
          op = tp_op[idx]; a = tp_a[idx]; b = tp_b[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      adv = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        sb.push_back(model(op, a, b, cyc));
        acc.push_back(cyc);
        idx++;
        adv = 1'b1;
      end
      if (idx == 4 && got == 4) break;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("tp_outputs", got, 4);
    check("tp_accepts", acc.size(), 4);
    check("tp_sb_empty", sb.size(), 0);
    for (int i = 1; i < acc.size(); i++)
      check("tp_accept_gap", acc[i] - acc[i-1], ACC_GAP);
    check("tp_idle_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
